// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin arbiter sharing one UART transmitter among NREQ byte
//           sources; tracks tre through a full character, then acks the winner.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int BUSY_TO = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic              baud_clk_posedge,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*8-1:0] data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              uart_wen_o,
  output logic [7:0]        uart_data_o,
  input  logic              uart_tre_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int                 c_PTR_W  = $clog2(NREQ);
  localparam int                 c_CNT_W  = $clog2(BUSY_TO + 1);
  localparam logic [c_PTR_W:0]   c_NREQ_V = (c_PTR_W + 1)'(NREQ);
  localparam logic [c_PTR_W-1:0] c_LAST   = c_PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WBUSY = 2'd2,
    S_WDONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_PTR_W-1:0]   r_rr;
  logic [c_PTR_W-1:0]   r_gidx;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [NREQ-1:0]      w_rot;
  logic                 w_found;
  logic [c_PTR_W-1:0]   w_off;
  logic [c_PTR_W:0]     w_sum;
  logic [c_PTR_W-1:0]   w_win;
  logic [NREQ-1:0]      w_onehot;
  logic [7:0]           w_data;
  logic [c_PTR_W-1:0]   w_next_rr;

  // Rotate requests so bit 0 is the rr pointer; the first set bit is the winner.
  always_comb begin
    w_rot   = NREQ'({req_i, req_i} >> r_rr);
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = c_PTR_W'(k);
      end
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_off};
    if (w_sum >= c_NREQ_V) begin
      w_sum = w_sum - c_NREQ_V;
    end
    w_win = w_sum[c_PTR_W-1:0];
  end

  always_comb begin
    w_onehot = '0;
    w_data   = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == c_PTR_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_data      = data_i[k*8 +: 8];
      end
    end
  end

  assign w_next_rr = (r_gidx == c_LAST) ? '0 : r_gidx + c_PTR_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_gidx      <= '0;
      r_cnt       <= '0;
      ack_o       <= '0;
      grant_o     <= '0;
      uart_wen_o  <= 1'b0;
      uart_data_o <= 8'h00;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      ack_o <= '0;
      err_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Requests seen during the ack cycle are stale: the source has not
          // yet had a chance to drop or refresh them.
          if (w_found && uart_tre_i && (ack_o == '0)) begin
            uart_data_o <= w_data;
            grant_o     <= w_onehot;
            r_gidx      <= w_win;
            uart_wen_o  <= 1'b1;
            busy_o      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (baud_clk_posedge) begin
            uart_wen_o <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_WBUSY;
          end
        end
        S_WBUSY: begin
          if (!uart_tre_i) begin
            r_state <= S_WDONE;
          end else if (baud_clk_posedge) begin
            if (r_cnt == c_CNT_W'(BUSY_TO - 1)) begin
              err_o   <= 1'b1;
              grant_o <= '0;
              busy_o  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
        end
        S_WDONE: begin
          if (uart_tre_i) begin
            ack_o   <= grant_o;
            r_rr    <= w_next_rr;
            grant_o <= '0;
            busy_o  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Self-checking bench for uart_tx_arbiter with a behavioural UART.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int BUSY_TO  = 16;
  localparam int BAUD_DIV = 4;
  localparam int FRAME    = 10;
  localparam int LIM      = 400;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_l = 1'b0;
  logic              baud      = 1'b0;
  logic [NREQ-1:0]   req       = '0;
  logic [NREQ*8-1:0] data      = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              wen;
  logic [7:0]        udata;
  logic              busy;
  logic              err;
  logic              tre_model = 1'b1;
  logic              ext_hold  = 1'b0;
  logic              stuck     = 1'b0;
  logic              uart_tre;

  assign uart_tre = tre_model & ~ext_hold;

  int errors = 0;
  int checks = 0;
  int exp_rr = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TO(BUSY_TO)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_l        (sys_rst_l),
    .baud_clk_posedge (baud),
    .req_i            (req),
    .data_i           (data),
    .ack_o            (ack),
    .grant_o          (grant),
    .uart_wen_o       (wen),
    .uart_data_o      (udata),
    .uart_tre_i       (uart_tre),
    .busy_o           (busy),
    .err_o            (err)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural UART: loads on a tick sampled with wen high, shifts FRAME ticks.
  int         div = 0;
  int         bits = 0;
  int         loads = 0;
  int         ticks_since_load = 0;
  logic       pend_load = 1'b0;
  logic       pend_tick = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  logic [7:0] rx_q[$];

  initial begin
    forever begin
      @(negedge sys_clk);
      if (pend_load) begin
        rx_q.push_back(pend_byte);
        loads++;
        if (!stuck) begin
          tre_model = 1'b0;
          bits      = FRAME;
        end
      end else if (pend_tick && !tre_model) begin
        bits--;
        if (bits == 0) tre_model = 1'b1;
      end
      div       = (div + 1) % BAUD_DIV;
      baud      = (div == 0);
      pend_load = wen && baud;
      pend_byte = udata;
      pend_tick = baud;
      if (pend_load) ticks_since_load = 0;
      else if (baud) ticks_since_load++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_grant(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference arbitration rule: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int s = (ptr + k) % NREQ;
      if (r[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [7:0] lane(input int k);
    return data[8*k +: 8];
  endfunction

  task automatic do_reset();
    sys_rst_l = 1'b0;
    req       = '0;
    stuck     = 1'b0;
    ext_hold  = 1'b0;
    repeat (3) step();
    sys_rst_l = 1'b1;
    exp_rr    = 0;
    repeat (FRAME * BAUD_DIV + 8) step();
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({ack, grant, wen, udata, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {ack, grant, wen, udata, busy, err});
    end
    sys_rst_l = 1'b1;
    repeat (4) step();
    checks++;
    if ({ack, grant, wen, udata, busy, err} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", {ack, grant, wen, udata, busy, err});
    end
  endtask

  task automatic test_single();
    bit   ok;
    logic prev_tre;
    int   l0;
    data[8*2 +: 8] = 8'h41;
    req = 4'b0100;
    wait_grant(20, ok);
    checks++;
    if (!ok || grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0100", grant);
    end
    checks++;
    if (udata !== 8'h41 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latch: data %h busy %b expected 41 1", udata, busy);
    end
    l0 = loads;
    ok = 1'b0;
    prev_tre = uart_tre;
    for (int i = 0; i < LIM; i++) begin
      step();
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
      prev_tre = uart_tre;
    end
    req = '0;
    checks++;
    if (!ok || ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack: got %b expected 0100", ack);
    end
    checks++;
    if (prev_tre !== 1'b0 || uart_tre !== 1'b1) begin
      errors++;
      $display("FAIL single_ack_timing: tre before %b now %b expected 0 1", prev_tre, uart_tre);
    end
    checks++;
    if (loads - l0 != 1 || rx_q.size() == 0 || rx_q[$] !== 8'h41) begin
      errors++;
      $display("FAIL single_wen_tick: loads %0d last rx %h expected 1 41", loads - l0,
               (rx_q.size() == 0) ? 8'h00 : rx_q[$]);
    end
    step();
    checks++;
    if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: ack %b grant %b busy %b expected 0 0 0", ack, grant, busy);
    end
    exp_rr = 3;
  endtask

  task automatic test_round_robin();
    bit ok;
    int src;
    do_reset();
    for (int k = 0; k < NREQ; k++) data[8*k +: 8] = 8'h10 + 8'(k);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      src = rr_pick(4'b1111, exp_rr);
      wait_ack(LIM, ok);
      if (n == 4) req = '0;
      checks++;
      if (!ok || ack !== 4'(1 << src)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %b expected source %0d", n, ack, src);
      end
      checks++;
      if (rx_q.size() == 0 || rx_q[$] !== 8'h10 + 8'(src)) begin
        errors++;
        $display("FAIL rr_rx[%0d]: got %h expected %h", n,
                 (rx_q.size() == 0) ? 8'h00 : rx_q[$], 8'h10 + 8'(src));
      end
      exp_rr = (src + 1) % NREQ;
    end
    step();
  endtask

  task automatic test_wrap();
    bit ok;
    int src;
    data[8*3 +: 8] = 8'h33;
    data[8*0 +: 8] = 8'h30;
    req = 4'b1000;
    wait_ack(LIM, ok);
    req = 4'b1001;
    checks++;
    if (!ok || ack !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_first: got %b expected 1000", ack);
    end
    exp_rr = 0;
    for (int n = 0; n < 2; n++) begin
      src = rr_pick(4'b1001, exp_rr);
      wait_ack(LIM, ok);
      if (n == 1) req = '0;
      checks++;
      if (!ok || ack !== 4'(1 << src) || src != ((n == 0) ? 0 : 3)) begin
        errors++;
        $display("FAIL wrap_next[%0d]: got %b expected source %0d", n, ack, (n == 0) ? 0 : 3);
      end
      exp_rr = (src + 1) % NREQ;
    end
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    int nack = 0;
    bit seen = 1'b0;
    data[8*1 +: 8] = 8'h5A;
    stuck = 1'b1;
    req = 4'b0010;
    wait_grant(20, ok);
    checks++;
    if (!ok || grant !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_grant: got %b expected 0010", grant);
    end
    for (int i = 0; i < BUSY_TO * BAUD_DIV + 40; i++) begin
      step();
      if (ack != '0) nack++;
      if (err) begin
        seen = 1'b1;
        break;
      end
    end
    stuck = 1'b0;
    checks++;
    if (!seen || ticks_since_load != BUSY_TO) begin
      errors++;
      $display("FAIL timeout_err: seen %b ticks %0d expected 1 %0d", seen, ticks_since_load, BUSY_TO);
    end
    checks++;
    if (nack != 0 || ack !== '0 || grant !== '0) begin
      errors++;
      $display("FAIL timeout_noack: acks %0d grant %b expected 0 0000", nack, grant);
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err %b expected 0", err);
    end
    ok = (grant != '0);
    if (!ok) wait_grant(20, ok);
    checks++;
    if (!ok || grant !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_regrant: got %b expected 0010", grant);
    end
    wait_ack(LIM, ok);
    req = '0;
    checks++;
    if (!ok || ack !== 4'b0010 || rx_q[$] !== 8'h5A) begin
      errors++;
      $display("FAIL timeout_retry_ack: ack %b rx %h expected 0010 5a", ack, rx_q[$]);
    end
    exp_rr = 2;
    step();
  endtask

  task automatic test_tre_busy();
    bit ok;
    int bad = 0;
    data[8*0 +: 8] = 8'h77;
    ext_hold = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wen || grant != '0 || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tre_busy_hold: active cycles %0d expected 0", bad);
    end
    ext_hold = 1'b0;
    wait_grant(20, ok);
    checks++;
    if (!ok || grant !== 4'(1 << rr_pick(4'b0001, exp_rr))) begin
      errors++;
      $display("FAIL tre_busy_grant: got %b expected 0001", grant);
    end
    wait_ack(LIM, ok);
    req = '0;
    checks++;
    if (!ok || ack !== 4'b0001 || rx_q[$] !== 8'h77) begin
      errors++;
      $display("FAIL tre_busy_ack: ack %b rx %h expected 0001 77", ack, rx_q[$]);
    end
    exp_rr = 1;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int act = 0;
    data[8*2 +: 8] = 8'h99;
    req = 4'b0100;
    wait_grant(20, ok);
    for (int i = 0; i < LIM; i++) begin
      step();
      if (!uart_tre) break;
    end
    repeat (3) step();
    checks++;
    if (!ok || busy !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_setup: busy %b grant %b expected 1 0100", busy, grant);
    end
    #2;
    sys_rst_l = 1'b0;
    #1;
    checks++;
    if ({ack, grant, wen, udata, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected 0", {ack, grant, wen, udata, busy, err});
    end
    req = '0;
    repeat (3) step();
    sys_rst_l = 1'b1;
    for (int i = 0; i < FRAME * BAUD_DIV + 20; i++) begin
      step();
      if (ack != '0 || wen || grant != '0) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_mid_noack: activity cycles %0d expected 0", act);
    end
    exp_rr = 0;
  endtask

  task automatic test_random();
    bit              ok;
    int              src;
    logic [NREQ-1:0] nw;
    req = '0;
    for (int it = 0; it < 20; it++) begin
      if (req == '0) begin
        nw = 4'($urandom_range(1, 15));
        for (int k = 0; k < NREQ; k++) if (nw[k]) data[8*k +: 8] = 8'($urandom);
        req = nw;
      end
      src = rr_pick(req, exp_rr);
      wait_grant(LIM, ok);
      checks++;
      if (!ok || grant !== 4'(1 << src) || udata !== lane(src)) begin
        errors++;
        $display("FAIL rand_grant[%0d]: grant %b data %h expected src %0d data %h",
                 it, grant, udata, src, lane(src));
      end
      wait_ack(LIM, ok);
      checks++;
      if (!ok || ack !== 4'(1 << src) || rx_q[$] !== lane(src)) begin
        errors++;
        $display("FAIL rand_ack[%0d]: ack %b rx %h expected src %0d data %h",
                 it, ack, rx_q[$], src, lane(src));
      end
      exp_rr = (src + 1) % NREQ;
      req[src] = 1'b0;
      nw = 4'($urandom_range(0, 15)) & ~req;
      for (int k = 0; k < NREQ; k++) if (nw[k]) data[8*k +: 8] = 8'($urandom);
      req = req | nw;
    end
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_tre_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
